// File: rtl/detector_patron_pkg.sv
// detector_patron_pkg: shared types and helpers for the serial pattern detector.
//   state_t    : control FSM encoding (UNCFG, ARMED)
//   len_width  : width of length/fill fields for a given maximum pattern length
//   sat_max    : all-ones value of a counter of the given width
package detector_patron_pkg;

  typedef enum logic {
    UNCFG = 1'b0,
    ARMED = 1'b1
  } state_t;

  // Must hold values 0..max_len inclusive.
  function automatic int len_width(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

  function automatic longint unsigned sat_max(input int width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/detector_patron_pulse_stretcher.sv
// pulse_stretcher: retriggerable LED hold for match strobes.
//   clk, reset : clock, synchronous active-high reset
//   match      : single-cycle strobe, sampled on the same edge that registers the match
//   led        : STRETCH=0 -> registered copy of match;
//                else high for STRETCH cycles starting with the match cycle, restart on retrigger
module pulse_stretcher #(
  parameter int STRETCH = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic match,
  output logic led
);

  generate
    if (STRETCH == 0) begin : g_pass
      logic r_led;
      always_ff @(posedge clk) begin
        if (reset) r_led <= 1'b0;
        else       r_led <= match;
      end
      assign led = r_led;
    end else begin : g_cnt
      localparam int CW = $clog2(STRETCH + 1);
      logic [CW-1:0] r_cnt;
      always_ff @(posedge clk) begin
        if (reset)              r_cnt <= '0;
        else if (match)         r_cnt <= CW'(STRETCH);
        else if (r_cnt != '0)   r_cnt <= r_cnt - CW'(1);
      end
      assign led = (r_cnt != '0);
    end
  endgenerate

endmodule

// File: rtl/detector_patron.sv
// detector_patron: runtime-configurable serial pattern detector.
//   clk, reset   : clock, synchronous active-high reset
//   in_valid/in_bit : serial input, one bit per cycle when in_valid
//   cfg_load, cfg_pattern, cfg_len, cfg_overlap : configuration load (pattern MSB = first bit)
//   clr_count    : clear match counter
//   armed        : valid configuration held
//   match        : one-cycle pulse per detected occurrence
//   match_count  : saturating match count
//   led          : stretched match indicator
//   cfg_err      : one-cycle pulse on rejected configuration
module detector_patron
  import detector_patron_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int STRETCH = 0,
  parameter int LEN_W   = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  output logic               armed,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               led,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(sat_max(CNT_W));

  state_t             r_state;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [CNT_W-1:0]   r_count;
  logic               r_match;
  logic               r_cfg_err;

  logic               w_cfg_ok;
  logic               w_shift;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_next;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_match;

  always_comb begin
    w_cfg_ok    = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    // cfg_load wins over in_valid: the coincident bit is dropped.
    w_shift     = in_valid && (r_state == ARMED) && !cfg_load;
    w_hist_next = w_shift ? {r_hist[MAX_LEN-2:0], in_bit} : r_hist;
    w_fill_next = r_fill;
    if (w_shift && (r_fill != MAX_LEN_L)) w_fill_next = r_fill + LEN_W'(1);
    w_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) w_mask[i] = (LEN_W'(i) < r_len);
    // Only a freshly shifted bit can complete an occurrence.
    w_match = w_shift && (w_fill_next >= r_len) &&
              (((w_hist_next ^ r_pattern) & w_mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= UNCFG;
      r_hist    <= '0;
      r_fill    <= '0;
      r_pattern <= '0;
      r_len     <= '0;
      r_overlap <= 1'b0;
      r_count   <= '0;
      r_match   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_match   <= w_match;
      r_cfg_err <= cfg_load && !w_cfg_ok;

      if (cfg_load && w_cfg_ok) begin
        r_state   <= ARMED;
        r_pattern <= cfg_pattern;
        r_len     <= cfg_len;
        r_overlap <= cfg_overlap;
        r_hist    <= '0;
        r_fill    <= '0;
      end else if (w_shift) begin
        r_hist <= w_hist_next;
        // Non-overlapping mode: restart the fill so matched bits are not reused.
        r_fill <= (w_match && !r_overlap) ? '0 : w_fill_next;
      end

      if (clr_count)                             r_count <= w_match ? CNT_W'(1) : '0;
      else if (w_match && (r_count != CNT_MAX))  r_count <= r_count + CNT_W'(1);
    end
  end

  // The stretcher sees the unregistered strobe so its LED rises with the match pulse.
  pulse_stretcher #(.STRETCH(STRETCH)) u_stretch (
    .clk   (clk),
    .reset (reset),
    .match (w_match),
    .led   (led)
  );

  assign armed       = (r_state == ARMED);
  assign match       = r_match;
  assign match_count = r_count;
  assign cfg_err     = r_cfg_err;

endmodule
